inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Instruction-supply stage directly upstream of the stack CPU.
- Holds the program in a local instruction memory and fetches the word at the CPU's pc_next.
- Presents the word on inst with inst_ready, then runs the CPU's ready/complete/invalidate handshake.
- Also provides a program-load port, a run gate, an out-of-range PC fault and a retired-instruction counter.

Parameters:
CPU_BIT_WIDTH, 32, width of instruction word and PC
IMEM_DEPTH, 256, number of instruction words
IMEM_ADDR_BITS, 8, log2(IMEM_DEPTH); width of prog_addr

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  asynchronous, active-high; clears all state except memory contents
run  input  1  enables fetching; program load only allowed while low
prog_we  input  1  program-word write strobe
prog_addr  input  IMEM_ADDR_BITS  program write address
prog_data  input  CPU_BIT_WIDTH  program write data
pc_next  input  CPU_BIT_WIDTH  address of next instruction, from CPU
inst_complete  input  1  CPU: low = instruction accepted/executing, high = done
inst  output  CPU_BIT_WIDTH  instruction word to CPU
inst_ready  output  1  inst valid
fault  output  1  sticky: pc_next out of range
retired_count  output  CPU_BIT_WIDTH  instructions completed since reset

Behaviour:
Reset values (asynchronous):
- inst=0, inst_ready=0, fault=0, retired_count=0, state=S_IDLE.
- Memory contents are retained across reset.

Memory:
- Synchronous write: prog_we honoured only in S_IDLE; writes in any other state are ignored.
- Synchronous read: 1-cycle latency.

State machine (registered, one transition per posedge):
- S_IDLE: inst_ready=0. Goes to S_READ when run=1.
- S_READ: samples pc_next.
  - If pc_next >= IMEM_DEPTH: go to S_FAULT.
  - Otherwise issue a memory read of pc_next[IMEM_ADDR_BITS-1:0] and go to S_CAPTURE.
- S_CAPTURE: register read data into inst; set inst_ready=1; go to S_PRESENT.
  - Latency: inst_ready rises 2 cycles after entering S_READ.
- S_PRESENT: inst and inst_ready held stable. Go to S_BUSY when inst_complete==0.
  - inst_complete is high out of CPU reset, so a high level here is not treated as completion.
- S_BUSY: inst_ready stays 1 (the CPU samples it only in fetch). Go to S_DROP when inst_complete==1.
- S_DROP: inst_ready=0, retired_count += 1 (wraps modulo 2^CPU_BIT_WIDTH).
  - Next state is S_READ if run=1, else S_IDLE.
  - inst_ready is therefore low for at least 3 cycles (DROP, READ, CAPTURE), which satisfies the CPU invalidate check.
  - pc_next is sampled in S_READ, one cycle after the CPU updated it.
- S_FAULT: fault=1, inst_ready=0. Terminal until reset; run and prog_we ignored.

Boundary rules:
- run falling mid-handshake: the current instruction completes normally; the block stops at S_DROP.
- pc_next == IMEM_DEPTH-1: legal. pc_next == IMEM_DEPTH: fault.
- prog_we together with run rising in S_IDLE: the write is performed and the state moves to S_READ. The read of that same address in S_READ returns the new data, because the write lands at the S_IDLE posedge.
- Reset asserted in any state: outputs clear immediately. The CPU must be reset alongside.
- inst is never changed while inst_ready=1.

Decomposition:
- Shared package: CPU_BIT_WIDTH and the opcode width/field constants shared with the CPU; the fetch-state encoding (3 bits, S_IDLE..S_FAULT).
- Sub-module inst_mem: single-port RAM, IMEM_DEPTH x CPU_BIT_WIDTH, synchronous write and registered read.
- The FSM and counter live in inst_fetch_unit.

Test Plan:
- Load: prog_we writes 0x0800_0005 at addr 0 with run=0, then run=1, pc_next=0 → inst=0x0800_0005 and inst_ready=1 exactly 2 cycles after S_READ entry; retired_count=0.
- Handshake: with the word presented, drive inst_complete 1→0 (3 cycles)→1 → inst_ready falls the cycle after inst_complete rises; retired_count=1; the next fetch uses the updated pc_next=1.
- Write lockout: prog_we at addr 3 with data 0xFFFF_FFFF while run=1 → memory at addr 3 unchanged (verified after run=0 by fetching addr 3).
- Fault: pc_next=256 (IMEM_DEPTH) at S_READ → fault=1, inst_ready stays 0 for 20 cycles; only reset clears fault.
- Stop: run dropped during S_BUSY → handshake finishes with retired_count incremented, then S_IDLE with inst_ready=0 and no further fetch.
- Async reset mid-S_PRESENT, asserted between clock edges → inst=0, inst_ready=0, retired_count=0 immediately; program contents intact on the next run.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the stack CPU it feeds.
package inst_fetch_unit_pkg;

  localparam int unsigned CpuBitWidth  = 32;
  localparam int unsigned ImemDepth    = 256;
  localparam int unsigned ImemAddrBits = 8;

  // Instruction word layout shared with the CPU: opcode in the top byte, operand below.
  localparam int unsigned OpcodeWidth  = 8;
  localparam int unsigned OpcodeLsb    = CpuBitWidth - OpcodeWidth;
  localparam int unsigned OperandWidth = OpcodeLsb;

  // Fetch FSM state encoding.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRead    = 3'd1,
    StCapture = 3'd2,
    StPresent = 3'd3,
    StBusy    = 3'd4,
    StDrop    = 3'd5,
    StFault   = 3'd6
  } fetch_state_e;

  function automatic logic [OpcodeWidth-1:0] inst_opcode(input logic [CpuBitWidth-1:0] word);
    return word[CpuBitWidth-1 -: OpcodeWidth];
  endfunction

endpackage

// File: rtl/inst_fetch_unit_mem.sv
// Single-port instruction RAM: synchronous write, registered read, no reset on contents.
module inst_mem
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH     = ImemDepth,
  parameter int unsigned ADDR_BITS = ImemAddrBits,
  parameter int unsigned WIDTH     = CpuBitWidth
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and read share the single address port; the fetch FSM never asks for both at once.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: program load port, fetch FSM with CPU handshake,
// out-of-range PC fault and retired-instruction counter.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned CPU_BIT_WIDTH  = CpuBitWidth,
  parameter int unsigned IMEM_DEPTH     = ImemDepth,
  parameter int unsigned IMEM_ADDR_BITS = ImemAddrBits
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      prog_we,
  input  logic [IMEM_ADDR_BITS-1:0] prog_addr,
  input  logic [CPU_BIT_WIDTH-1:0]  prog_data,
  input  logic [CPU_BIT_WIDTH-1:0]  pc_next,
  input  logic                      inst_complete,
  output logic [CPU_BIT_WIDTH-1:0]  inst,
  output logic                      inst_ready,
  output logic                      fault,
  output logic [CPU_BIT_WIDTH-1:0]  retired_count
);

  fetch_state_e state_q, state_d;

  logic [CPU_BIT_WIDTH-1:0]  inst_q;
  logic [CPU_BIT_WIDTH-1:0]  retired_q;
  logic                      pc_in_range;
  logic                      mem_we;
  logic                      mem_re;
  logic [IMEM_ADDR_BITS-1:0] mem_addr;
  logic [CPU_BIT_WIDTH-1:0]  mem_rdata;

  assign pc_in_range = pc_next < CPU_BIT_WIDTH'(IMEM_DEPTH);

  // Loads only land while idle; reads are issued only from the READ state with a legal PC.
  assign mem_we   = prog_we && (state_q == StIdle);
  assign mem_re   = (state_q == StRead) && pc_in_range;
  assign mem_addr = (state_q == StRead) ? pc_next[IMEM_ADDR_BITS-1:0] : prog_addr;

  inst_mem #(
    .DEPTH    (IMEM_DEPTH),
    .ADDR_BITS(IMEM_ADDR_BITS),
    .WIDTH    (CPU_BIT_WIDTH)
  ) u_inst_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(prog_data),
    .rdata(mem_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (run) state_d = StRead;
      StRead:    state_d = pc_in_range ? StCapture : StFault;
      StCapture: state_d = StPresent;
      // inst_complete idles high out of CPU reset, so only a low level means acceptance.
      StPresent: if (!inst_complete) state_d = StBusy;
      StBusy:    if (inst_complete) state_d = StDrop;
      StDrop:    state_d = run ? StRead : StIdle;
      StFault:   state_d = StFault;
      default:   state_d = StIdle;
    endcase
  end

  // Instruction word and retired counter; inst only changes in CAPTURE, when inst_ready is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q    <= '0;
      retired_q <= '0;
    end else begin
      if (state_q == StCapture) begin
        inst_q <= mem_rdata;
      end
      if (state_q == StDrop) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    inst          = inst_q;
    retired_count = retired_q;
    inst_ready    = (state_q == StPresent) || (state_q == StBusy);
    fault         = (state_q == StFault);
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus pushes expected fetches, a monitor
// pops and compares on each rising inst_ready.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] pc_next;
  logic        inst_complete;
  logic [31:0] inst;
  logic        inst_ready;
  logic        fault;
  logic [31:0] retired_count;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] retired;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic rdy_prev = 1'b0;

  inst_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .pc_next      (pc_next),
    .inst_complete(inst_complete),
    .inst         (inst),
    .inst_ready   (inst_ready),
    .fault        (fault),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every rising edge of inst_ready must match the oldest expected fetch.
  always @(negedge clk) begin
    if (inst_ready && !rdy_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got inst 0x%08h, expected no fetch", inst);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("fetch_inst", inst, e.inst);
        check("fetch_retired", retired_count, e.retired);
        check("fetch_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    rdy_prev <= inst_ready;
  end

  task automatic push_exp(input logic [31:0] i, input logic [31:0] r, input int delay);
    exp_t e;
    e.inst    = i;
    e.retired = r;
    e.cyc     = cyc + delay;
    exp_q.push_back(e);
  endtask

  task automatic prog_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: inst_ready got 0 for 20 cycles, expected 1", name);
    end
  endtask

  // Drive one complete handshake; the CPU updates pc_next as it signals completion.
  task automatic handshake(input logic [31:0] new_pc, input bit expect_next,
                           input logic [31:0] exp_inst, input logic [31:0] exp_ret,
                           input bit drop_run);
    @(posedge clk); #1;
    inst_complete = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (drop_run) run = 1'b0;
    pc_next       = new_pc;
    inst_complete = 1'b1;
    if (expect_next) push_exp(exp_inst, exp_ret, 4);
    @(posedge clk);
    @(negedge clk);
    check("ready_drop", {31'd0, inst_ready}, 32'd0);
    if (expect_next) wait_ready("next_fetch");
  endtask

  initial begin
    bit quiet;
    reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    pc_next = '0; inst_complete = 1'b1;
    #12;
    check("reset_inst", inst, 32'd0);
    check("reset_ready", {31'd0, inst_ready}, 32'd0);
    check("reset_fault", {31'd0, fault}, 32'd0);
    check("reset_retired", retired_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    prog_write(8'd0, 32'h0800_0005);
    prog_write(8'd1, 32'h1111_2222);
    prog_write(8'd2, 32'h0000_00AB);
    prog_write(8'd3, 32'h3333_4444);
    prog_write(8'd255, 32'hDEAD_BEEF);

    // Load and first fetch.
    @(posedge clk); #1;
    pc_next = 32'd0;
    push_exp(32'h0800_0005, 32'd0, 3);
    run = 1'b1;
    wait_ready("load");

    // Handshake, then fetch of the updated PC, then the last legal address.
    handshake(32'd1, 1'b1, 32'h1111_2222, 32'd1, 1'b0);
    handshake(32'd255, 1'b1, 32'hDEAD_BEEF, 32'd2, 1'b0);

    // Write attempt while running must be ignored.
    prog_write(8'd3, 32'hFFFF_FFFF);

    // Run dropped mid-handshake: the instruction retires and the block idles.
    handshake(32'd3, 1'b0, 32'd0, 32'd0, 1'b1);
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (inst_ready) quiet = 1'b0;
    end
    check("stop_no_fetch", {31'd0, quiet}, 32'd1);
    check("stop_retired", retired_count, 32'd3);

    // Fetch addr 3 to confirm the locked-out write did not land.
    @(posedge clk); #1;
    push_exp(32'h3333_4444, 32'd3, 3);
    run = 1'b1;
    wait_ready("lockout_fetch");

    // Asynchronous reset between clock edges while presenting.
    @(negedge clk); #2;
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check("async_reset_inst", inst, 32'd0);
    check("async_reset_ready", {31'd0, inst_ready}, 32'd0);
    check("async_reset_retired", retired_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Program survives reset.
    @(posedge clk); #1;
    pc_next = 32'd2;
    push_exp(32'h0000_00AB, 32'd0, 3);
    run = 1'b1;
    wait_ready("post_reset_fetch");

    // Next PC equals the memory depth: fault.
    handshake(32'd256, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("fault_set", {31'd0, fault}, 32'd1);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (inst_ready || !fault) quiet = 1'b0;
    end
    check("fault_sticky_20", {31'd0, quiet}, 32'd1);

    @(posedge clk); #1;
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check("fault_cleared", {31'd0, fault}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation got 50000 ns, expected earlier finish");
    $fatal(1);
  end

endmodule
